// File: rtl/khazad_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the KHAZAD theta layer.
package khazad_pkg;

  localparam int unsigned KHZ_BYTES  = 8;
  localparam int unsigned KHZ_BYTE_W = 8;
  localparam int unsigned KHZ_COEF_W = 4;
  localparam int unsigned KHZ_CNT_W  = 3;
  localparam int unsigned KHZ_DATA_W = KHZ_BYTES * KHZ_BYTE_W;
  localparam int unsigned KHZ_ROW_W  = KHZ_BYTES * KHZ_COEF_W;

  localparam logic [KHZ_ROW_W-1:0] KHZ_ROW0 = 32'h134568B7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x^2+1 (0x11D).
  function automatic logic [KHZ_BYTE_W-1:0] gf_xtime(input logic [KHZ_BYTE_W-1:0] a);
    return {a[KHZ_BYTE_W-2:0], 1'b0} ^ (a[KHZ_BYTE_W-1] ? 8'h1D : 8'h00);
  endfunction

  // H coefficients are only 4 bits wide, so four xtime steps cover the product.
  function automatic logic [KHZ_BYTE_W-1:0] gf_mul4(input logic [KHZ_BYTE_W-1:0] a,
                                                    input logic [KHZ_COEF_W-1:0] c);
    logic [KHZ_BYTE_W-1:0] p;
    logic [KHZ_BYTE_W-1:0] t;
    p = '0;
    t = a;
    for (int k = 0; k < int'(KHZ_COEF_W); k++) begin
      if (c[k]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/khazad_row_mult.sv
// Expands one state byte into a 64-bit partial product: byte j = x_i * H[i][j].
module khazad_row_mult
  import khazad_pkg::*;
(
  input  logic [7:0]  i_byte,
  input  logic [31:0] i_row,
  output logic [63:0] o_prod
);

  for (genvar j = 0; j < int'(KHZ_BYTES); j++) begin : g_col
    assign o_prod[KHZ_DATA_W-1-KHZ_BYTE_W*j -: KHZ_BYTE_W] =
      gf_mul4(i_byte, i_row[KHZ_ROW_W-1-KHZ_COEF_W*j -: KHZ_COEF_W]);
  end

endmodule

// File: rtl/khazad_row_select.sv
// Row i of the dyadic matrix H: coefficient for column j is ROW0 nibble (i XOR j).
module khazad_row_select
  import khazad_pkg::*;
(
  input  logic [2:0]  i_cnt,
  output logic [31:0] o_row
);

  logic [3:0] w_coef [KHZ_BYTES];

  for (genvar g = 0; g < int'(KHZ_BYTES); g++) begin : g_coef
    assign w_coef[g] = KHZ_ROW0[KHZ_ROW_W-1-KHZ_COEF_W*g -: KHZ_COEF_W];
  end

  for (genvar j = 0; j < int'(KHZ_BYTES); j++) begin : g_row
    assign o_row[KHZ_ROW_W-1-KHZ_COEF_W*j -: KHZ_COEF_W] = w_coef[i_cnt ^ 3'(j)];
  end

endmodule

// File: rtl/khazad_theta_serial.sv
// Byte-serial KHAZAD theta layer: y = x * H over GF(2^8), one row per cycle, XOR-accumulated.
module khazad_theta_serial
  import khazad_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  state_e                  r_state;
  state_e                  w_nxt;
  logic [KHZ_CNT_W-1:0]    r_cnt;
  logic [KHZ_DATA_W-1:0]   r_acc;
  logic [KHZ_DATA_W-1:0]   r_x;
  logic                    r_out_valid;
  logic [KHZ_DATA_W-1:0]   r_out_data;
  logic                    r_in_ready;
  logic                    r_busy;

  logic [KHZ_DATA_W-1:0]   w_x_shift;
  logic [KHZ_BYTE_W-1:0]   w_byte;
  logic [KHZ_ROW_W-1:0]    w_row;
  logic [KHZ_DATA_W-1:0]   w_prod;
  logic                    w_accept;
  logic                    w_run;
  logic                    w_load_out;
  logic                    w_consume;

  // Byte cnt of the latched state, MSB byte first.
  assign w_x_shift = r_x << {r_cnt, 3'b000};
  assign w_byte    = w_x_shift[KHZ_DATA_W-1 -: KHZ_BYTE_W];

  khazad_row_select u_row_select (
    .i_cnt (r_cnt),
    .o_row (w_row)
  );

  khazad_row_mult u_row_mult (
    .i_byte (w_byte),
    .i_row  (w_row),
    .o_prod (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_nxt = S_RUN;
      S_RUN:   if (r_cnt == 3'd7) w_nxt = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // DONE spends its first cycle copying acc into the output register.
  always_comb begin
    w_accept   = 1'b0;
    w_run      = 1'b0;
    w_load_out = 1'b0;
    w_consume  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept   = in_valid;
      S_RUN:   w_run      = 1'b1;
      S_DONE: begin
        w_load_out = !r_out_valid;
        w_consume  = r_out_valid && out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= in_data;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_run) begin
        r_acc <= r_acc ^ w_prod;
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_load_out) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_acc;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      r_in_ready <= (w_nxt == S_IDLE);
      r_busy     <= (w_nxt != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
